// File: rtl/write_buffer.sv
// Posted-write buffer between a cache memory port and main memory: queues word
// writes, drains them in FIFO order, and forwards read data when WRITE_BUFFER_FORWARD_EN is defined.
module write_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready,
  output logic [1:0]            dbg_ustate,
  output logic [1:0]            dbg_dstate,
  output logic [DEPTH_BITS:0]   dbg_count
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

  localparam logic [1:0] U_IDLE = 2'd0;
  localparam logic [1:0] U_ACK  = 2'd1;
  localparam logic [1:0] U_READ = 2'd2;

  localparam logic [1:0] D_IDLE   = 2'd0;
  localparam logic [1:0] D_STROBE = 2'd1;
  localparam logic [1:0] D_GAP    = 2'd2;
  localparam logic [1:0] D_WAIT   = 2'd3;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic [1:0]            ustate;
  logic [1:0]            dstate;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  d_read;

  logic full;
  logic accept_rd;
  logic accept_wr;
  logic push;
  logic pop;
  logic rd_req;
  logic start_rd;
  logic start_wr;
  logic drain_done;
  logic rd_done;

  // Upstream handshake: a request (re or we) is taken on a rising edge only
  // when ready=1 in that cycle; re has priority over we. ready=1 again later
  // means the previous request has fully completed (dout valid for reads).
  assign full      = (count == FULL_COUNT);
  assign ready     = (ustate == U_IDLE) && !full && !rst;
  assign accept_rd = ready && re;
  assign accept_wr = ready && we && !re;
  assign push      = accept_wr;

`ifdef WRITE_BUFFER_FORWARD_EN
  logic                  fwd_hit;
  logic [WORD_WIDTH-1:0] fwd_data;
  logic [DEPTH_BITS-1:0] idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + DEPTH_BITS'(i);
      if (((DEPTH_BITS + 1)'(i) < count) && (addr_mem[idx] == addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  // Misses bypass queued writes: none of them can alias the read address.
  assign rd_req = (ustate == U_READ);
`else
  // Without forwarding the read is strictly ordered behind every queued write.
  assign rd_req = (ustate == U_READ) && (count == '0);
`endif

  assign start_rd   = (dstate == D_IDLE) && rd_req && mready;
  assign start_wr   = (dstate == D_IDLE) && !rd_req && (count != '0) && mready;
  assign drain_done = (dstate == D_WAIT) && mready;
  assign pop        = drain_done && !d_read;
  assign rd_done    = drain_done && d_read;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= addr;
      data_mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ustate  <= U_IDLE;
      dstate  <= D_IDLE;
      rd_addr <= '0;
      d_read  <= 1'b0;
      dout    <= '0;
      maddr   <= '0;
      mout    <= '0;
      mre     <= 1'b0;
      mwe     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (ustate)
        U_IDLE: begin
          if (accept_rd) begin
`ifdef WRITE_BUFFER_FORWARD_EN
            if (fwd_hit) begin
              dout   <= fwd_data;
              ustate <= U_ACK;
            end else begin
              rd_addr <= addr;
              ustate  <= U_READ;
            end
`else
            rd_addr <= addr;
            ustate  <= U_READ;
`endif
          end else if (accept_wr) begin
            ustate <= U_ACK;
          end
        end
        U_ACK: ustate <= U_IDLE;
        U_READ: begin
          if (rd_done) begin
            dout   <= min;
            ustate <= U_IDLE;
          end
        end
        default: ustate <= U_IDLE;
      endcase

      // Strobes are single-cycle pulses that live only in D_STROBE.
      mre <= 1'b0;
      mwe <= 1'b0;
      case (dstate)
        D_IDLE: begin
          if (start_rd) begin
            maddr  <= rd_addr;
            mre    <= 1'b1;
            d_read <= 1'b1;
            dstate <= D_STROBE;
          end else if (start_wr) begin
            maddr  <= addr_mem[rd_ptr];
            mout   <= data_mem[rd_ptr];
            mwe    <= 1'b1;
            d_read <= 1'b0;
            dstate <= D_STROBE;
          end
        end
        D_STROBE: dstate <= D_GAP;
        // mready may still show the previous idle level here.
        D_GAP:    dstate <= D_WAIT;
        D_WAIT: begin
          if (mready) dstate <= D_IDLE;
        end
      endcase
    end
  end

  assign dbg_ustate = ustate;
  assign dbg_dstate = dstate;
  assign dbg_count  = count;

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed scenarios plus random traffic against a
// shadow-memory reference and a memory-side responder model.
`timescale 1ns/1ps
module tb_write_buffer;
  localparam int AW = 64;
  localparam int WW = 64;
  localparam int DB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [WW-1:0] din = '0;
  logic [WW-1:0] dout;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic          ready;
  logic [AW-1:0] maddr;
  logic [WW-1:0] mout;
  logic [WW-1:0] min = '0;
  logic          mre;
  logic          mwe;
  logic          mready = 1'b1;
  logic [1:0]    dbg_ustate;
  logic [1:0]    dbg_dstate;
  logic [DB:0]   dbg_count;

  write_buffer #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH_BITS(DB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
    .ready(ready), .maddr(maddr), .mout(mout), .min(min), .mre(mre), .mwe(mwe),
    .mready(mready), .dbg_ustate(dbg_ustate), .dbg_dstate(dbg_dstate),
    .dbg_count(dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [AW+WW-1:0] exp_q[$];        // expected drain writes {addr, data}
  logic [AW:0]      ev_q[$];         // memory strobes seen {is_read, addr}
  logic [WW-1:0]    mem [logic [AW-1:0]];
  logic [WW-1:0]    shadow [logic [AW-1:0]];
  logic [AW-1:0]    exp_rd_addr = '0;
  logic [AW+WW-1:0] mon_e;
  int n_mre = 0;
  int n_mwe = 0;

  logic          mem_stall = 1'b0;
  logic          busy_active = 1'b0;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_a = '0;
  int            busy = 0;
  int            lat_lo = 0;
  int            lat_hi = 2;

  function automatic logic [WW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 64'h5a5a_0000_c3c3_0000;
  endfunction

  function automatic logic [WW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [WW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // memory responder: mready drops after a strobe and rises after a latency
  always @(negedge clk) begin
    if (mre || mwe) begin
      if (mwe) mem[maddr] = mout;
      rd_pend = mre;
      rd_a = maddr;
      busy_active = 1'b1;
      busy = $urandom_range(lat_hi, lat_lo);
      mready = 1'b0;
    end else if (busy_active) begin
      if (busy > 0) busy--;
      else if (!mem_stall) begin
        busy_active = 1'b0;
        mready = 1'b1;
        if (rd_pend) min = mem_rd(rd_a);
      end
    end else begin
      mready = !mem_stall;
    end
  end

  // scoreboard on the memory side
  always @(negedge clk) begin
    if (mwe) begin
      n_mwe++;
      ev_q.push_back({1'b0, maddr});
      check("mwe_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("mwe_addr", maddr, mon_e[AW+WW-1:WW]);
        check("mwe_data", mout, mon_e[WW-1:0]);
      end
    end
    if (mre) begin
      n_mre++;
      ev_q.push_back({1'b1, maddr});
      check("mre_addr", maddr, exp_rd_addr);
    end
  end

  // driver tasks
  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("wait_ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic issue(input logic is_rd, input logic [AW-1:0] a, input logic [WW-1:0] d);
    re = is_rd;
    we = !is_rd;
    addr = a;
    din = d;
    if (is_rd) exp_rd_addr = a;
    else begin
      exp_q.push_back({a, d});
      shadow[a] = d;
    end
    @(negedge clk);
    re = 1'b0;
    we = 1'b0;
  endtask

  task automatic finish_op(output int n);
    n = 1;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("op_timeout", 64'(ready), 64'd1);
  endtask

  task automatic do_op(input logic is_rd, input logic [AW-1:0] a, input logic [WW-1:0] d, output int n);
    wait_ready();
    issue(is_rd, a, d);
    finish_op(n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((dbg_count != '0 || exp_q.size() != 0 || !mready) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("idle_count", 64'(dbg_count), 64'd0);
  endtask

  task automatic wait_mwe(input int base);
    int k = 0;
    while (n_mwe <= base && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mwe_seen", 64'(n_mwe > base), 64'd1);
  endtask

  task automatic stall_mem();
    mem_stall = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_ev(input int i, input logic is_rd, input logic [AW-1:0] a);
    if (i < ev_q.size()) begin
      check($sformatf("ev%0d_kind", i), 64'(ev_q[i][AW]), 64'(is_rd));
      check($sformatf("ev%0d_addr", i), ev_q[i][AW-1:0], a);
    end
  endtask

  initial begin
    int n;
    int base;
    logic [AW-1:0] a;
    logic [WW-1:0] d;

    // reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_mre", 64'(mre), 64'd0);
    check("rst_mwe", 64'(mwe), 64'd0);
    check("rst_maddr", maddr, 64'd0);
    check("rst_mout", mout, 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_count", 64'(dbg_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(ready), 64'd1);
    repeat (5) @(negedge clk);
    check("idle_no_traffic", 64'(n_mre + n_mwe), 64'd0);

    // single write with a fixed memory latency
    lat_lo = 2;
    lat_hi = 2;
    base = n_mwe;
    do_op(1'b0, 64'h10, 64'hAA, n);
    check("write_latency", 64'(n), 64'd2);
    wait_idle();
    check("single_write_strobes", 64'(n_mwe - base), 64'd1);
    check("single_write_mem", mem_rd(64'h10), 64'hAA);

    // fill with memory stalled
    lat_lo = 0;
    lat_hi = 2;
    stall_mem();
    base = n_mwe;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 64'h200 + 64'(8 * i), 64'h1000 + 64'(i), n);
      check("fill_write_latency", 64'(n), 64'd2);
    end
    wait_ready();
    issue(1'b0, 64'h218, 64'h1003);
    repeat (4) begin
      check("full_ready_low", 64'(ready), 64'd0);
      check("full_count", 64'(dbg_count), 64'd4);
      @(negedge clk);
    end
    mem_stall = 1'b0;
    wait_ready();
    check("full_release_count", 64'(dbg_count), 64'd3);
    check("full_release_drained", 64'(n_mwe - base), 64'd1);
    do_op(1'b0, 64'h220, 64'h1004, n);
    wait_idle();
    check("fill_strobes", 64'(n_mwe - base), 64'd5);

    // forward: two writes to one address, then read it with memory stalled
    stall_mem();
    ev_q.delete();
    base = n_mre;
    do_op(1'b0, 64'h20, 64'd1, n);
    do_op(1'b0, 64'h20, 64'd2, n);
`ifdef WRITE_BUFFER_FORWARD_EN
    do_op(1'b1, 64'h20, '0, n);
    check("fwd_latency", 64'(n), 64'd2);
    check("fwd_dout", dout, shadow_rd(64'h20));
    check("fwd_no_mre", 64'(n_mre - base), 64'd0);
    mem_stall = 1'b0;
    wait_idle();
    check("fwd_ev_count", 64'(ev_q.size()), 64'd2);
`else
    wait_ready();
    issue(1'b1, 64'h20, '0);
    repeat (8) @(negedge clk);
    check("ord_read_waits", 64'(ready), 64'd0);
    check("ord_no_mre_yet", 64'(n_mre - base), 64'd0);
    mem_stall = 1'b0;
    finish_op(n);
    check("ord_dout", dout, shadow_rd(64'h20));
    wait_idle();
    check("ord_ev_count", 64'(ev_q.size()), 64'd3);
    check_ev(0, 1'b0, 64'h20);
    check_ev(1, 1'b0, 64'h20);
    check_ev(2, 1'b1, 64'h20);
`endif

    // read miss while writes are queued
    mem[64'h50] = 64'h55;
    shadow[64'h50] = 64'h55;
    lat_lo = 2;
    lat_hi = 3;
    stall_mem();
    ev_q.delete();
    do_op(1'b0, 64'h30, 64'h33, n);
    do_op(1'b0, 64'h40, 64'h44, n);
    base = n_mwe;
    mem_stall = 1'b0;
    wait_mwe(base);
    do_op(1'b1, 64'h50, '0, n);
    check("miss_dout", dout, 64'h55);
    wait_idle();
    check("miss_ev_count", 64'(ev_q.size()), 64'd3);
    check_ev(0, 1'b0, 64'h30);
`ifdef WRITE_BUFFER_FORWARD_EN
    check_ev(1, 1'b1, 64'h50);
    check_ev(2, 1'b0, 64'h40);
`else
    check_ev(1, 1'b0, 64'h40);
    check_ev(2, 1'b1, 64'h50);
`endif

    // reset while a drain write waits for memory
    lat_lo = 4;
    lat_hi = 5;
    stall_mem();
    do_op(1'b0, 64'h60, 64'h66, n);
    do_op(1'b0, 64'h68, 64'h67, n);
    do_op(1'b0, 64'h70, 64'h68, n);
    check("pre_rst_count", 64'(dbg_count), 64'd3);
    base = n_mwe;
    mem_stall = 1'b0;
    wait_mwe(base);
    mem_stall = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_drain_count", 64'(dbg_count), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_count", 64'(dbg_count), 64'd0);
    check("mid_rst_mwe", 64'(mwe), 64'd0);
    check("mid_rst_mre", 64'(mre), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    shadow = mem;
    base = n_mre + n_mwe;
    repeat (20) @(negedge clk);
    check("post_rst_no_strobes", 64'(n_mre + n_mwe - base), 64'd0);
    check("post_rst_ready", 64'(ready), 64'd1);
    check("post_rst_dout", dout, 64'd0);

    // random traffic against the shadow memory
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 80; i++) begin
      a = 64'h100 + 64'(8 * $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        do_op(1'b1, a, '0, n);
        check("rand_read", dout, shadow_rd(a));
      end else begin
        d = {$urandom, $urandom};
        do_op(1'b0, a, d, n);
      end
    end
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      a = 64'h100 + 64'(8 * i);
      check("rand_final_mem", mem_rd(a), shadow_rd(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
